// File: rtl/alignment_pkg.sv
// Shared types and constants for the alignment run controller.
package alignment_pkg;

    localparam int unsigned SCORE_W   = 32;
    localparam int unsigned JOB_CNT_W = 16;
    localparam int unsigned DEFAULT_N = 100;
    localparam int unsigned DEFAULT_M = 200;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LAUNCH,
        RUN,
        HOLD
    } ctrl_state_t;

endpackage

// File: rtl/alignment_timer.sv
// Shared up-counter for the CLEAR hold and the RUN watchdog; expire flags the last cycle.
module alignment_timer #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign expire = (count_q == limit);

    // Holds at the terminal value so the counter can never wrap.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (enable && !expire) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alignment_controller.sv
// Sequences one systolic alignment job: clear generator, launch, watch for finish or
// timeout, then hold the result until the host acknowledges it.
module alignment_controller
    import alignment_pkg::*;
#(
    parameter int unsigned N          = DEFAULT_N,
    parameter int unsigned M          = DEFAULT_M,
    parameter int unsigned TIMEOUT    = N + M + 16,
    parameter int unsigned CLR_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_valid,
    output logic                 job_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [SCORE_W-1:0]   res_score,
    output logic                 res_timeout,
    output logic                 gen_reset,
    output logic                 gen_start,
    input  logic                 gen_finish,
    input  logic [SCORE_W-1:0]   gen_solution,
    output logic                 busy,
    output logic [JOB_CNT_W-1:0] job_count
);

    localparam int unsigned CNT_MAX = (TIMEOUT > CLR_CYCLES) ? TIMEOUT : CLR_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT - 1);

    ctrl_state_t            state_q,       state_d;
    logic [SCORE_W-1:0]     res_score_q,   res_score_d;
    logic                   res_timeout_q, res_timeout_d;
    logic [JOB_CNT_W-1:0]   job_count_q,   job_count_d;

    logic                   tmr_load;
    logic                   tmr_enable;
    logic [CNT_W-1:0]       tmr_limit;
    logic                   tmr_expire;

    alignment_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .enable (tmr_enable),
        .limit  (tmr_limit),
        .expire (tmr_expire)
    );

    // Next-state and result capture; finish takes priority over timeout.
    always_comb begin
        state_d       = state_q;
        res_score_d   = res_score_q;
        res_timeout_d = res_timeout_q;
        job_count_d   = job_count_q;
        tmr_load      = 1'b0;
        tmr_enable    = 1'b0;
        tmr_limit     = CLR_LAST;

        case (state_q)
            IDLE: begin
                if (job_valid) begin
                    tmr_load = 1'b1;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                tmr_limit = CLR_LAST;
                if (tmr_expire) begin
                    state_d = LAUNCH;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            LAUNCH: begin
                tmr_load = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                tmr_limit  = RUN_LAST;
                tmr_enable = 1'b1;
                if (gen_finish) begin
                    res_score_d   = gen_solution;
                    res_timeout_d = 1'b0;
                    state_d       = HOLD;
                end else if (tmr_expire) begin
                    res_score_d   = '0;
                    res_timeout_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    job_count_d = job_count_q + JOB_CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            res_score_q   <= '0;
            res_timeout_q <= 1'b0;
            job_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            res_score_q   <= res_score_d;
            res_timeout_q <= res_timeout_d;
            job_count_q   <= job_count_d;
        end
    end

    // Handshake and generator controls come straight from the state register.
    assign job_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign gen_start   = (state_q == LAUNCH);
    assign res_valid   = (state_q == HOLD);
    assign gen_reset   = !reset || (state_q == CLEAR);
    assign res_score   = res_score_q;
    assign res_timeout = res_timeout_q;
    assign job_count   = job_count_q;

endmodule

// File: tb/tb_alignment_controller.sv
// Self-checking bench for alignment_controller with a result scoreboard.
module tb_alignment_controller;

    localparam int TIMEOUT = 100 + 200 + 16;

    typedef struct packed {
        logic [31:0] score;
        logic        timeout;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        job_valid;
    logic        job_ready;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_score;
    logic        res_timeout;
    logic        gen_reset;
    logic        gen_start;
    logic        gen_finish;
    logic [31:0] gen_solution;
    logic        busy;
    logic [15:0] job_count;

    int          checks = 0;
    int          errors = 0;
    int          start_cnt = 0;
    logic [15:0] exp_jobs = '0;
    exp_t        sb_q[$];

    alignment_controller dut (
        .clk          (clk),
        .reset        (reset),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_score    (res_score),
        .res_timeout  (res_timeout),
        .gen_reset    (gen_reset),
        .gen_start    (gen_start),
        .gen_finish   (gen_finish),
        .gen_solution (gen_solution),
        .busy         (busy),
        .job_count    (job_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: pop the expected result on every accepted handshake.
    always @(posedge clk) begin
        if (reset && gen_start) start_cnt++;
        if (reset && res_valid && res_ready) begin
            exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got score=%h timeout=%b, required no result", res_score, res_timeout);
            end else begin
                e = sb_q.pop_front();
                if (res_score !== e.score || res_timeout !== e.timeout) begin
                    errors++;
                    $display("FAIL sb_result: got score=%h timeout=%b, required score=%h timeout=%b",
                             res_score, res_timeout, e.score, e.timeout);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; job_valid = 1'b0; res_ready = 1'b0; gen_finish = 1'b0; gen_solution = '0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (gen_reset !== 1'b1 || gen_start !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 ||
            res_score !== 32'h0 || res_timeout !== 1'b0 || job_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: got rst=%b st=%b rv=%b busy=%b sc=%h to=%b jc=%h, required 1 0 0 0 0 0 0",
                     gen_reset, gen_start, res_valid, busy, res_score, res_timeout, job_count);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (job_ready !== 1'b1 || gen_reset !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got job_ready=%b gen_reset=%b, required 1 0", job_ready, gen_reset);
        end
    endtask

    // One job: job_valid in cycle 0, finish in absolute cycle fin (0 = never), result held stall cycles.
    task automatic run_job(input string name, input int fin, input logic [31:0] sol,
                           input int stall, input bit hold_valid);
        int          exp_cyc;
        int          starts0;
        logic [31:0] es;
        logic        et;
        exp_cyc = (fin == 0) ? 3 + TIMEOUT + 1 : fin + 1;
        es      = (fin == 0) ? 32'h0 : sol;
        et      = (fin == 0);
        @(negedge clk);
        checks++;
        if (job_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: got job_ready=%b, required 1", name, job_ready);
        end
        job_valid    = 1'b1;
        gen_solution = sol;
        starts0      = start_cnt;
        sb_q.push_back('{score: es, timeout: et});
        for (int k = 1; k <= exp_cyc + stall; k++) begin
            @(negedge clk);
            if (!hold_valid) job_valid = 1'b0;
            checks++;
            if (gen_reset !== (k == 1 || k == 2) || gen_start !== (k == 3) ||
                res_valid !== (k >= exp_cyc) || job_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_cycle%0d: got rst=%b st=%b rv=%b jr=%b busy=%b, required %b %b %b 0 1",
                         name, k, gen_reset, gen_start, res_valid, job_ready, busy,
                         (k == 1 || k == 2), (k == 3), (k >= exp_cyc));
            end
            if (k >= exp_cyc) begin
                checks++;
                if (res_score !== es || res_timeout !== et) begin
                    errors++;
                    $display("FAIL %s_hold%0d: got score=%h timeout=%b, required score=%h timeout=%b",
                             name, k, res_score, res_timeout, es, et);
                end
            end
            gen_finish = (k == fin) || (k == 2);
            res_ready  = (k == exp_cyc + stall);
        end
        @(negedge clk);
        job_valid = 1'b0; res_ready = 1'b0; gen_finish = 1'b0;
        exp_jobs  = exp_jobs + 16'd1;
        checks++;
        if (res_valid !== 1'b0 || job_ready !== 1'b1 || job_count !== exp_jobs || start_cnt - starts0 != 1) begin
            errors++;
            $display("FAIL %s_done: got rv=%b jr=%b jc=%h starts=%0d, required 0 1 %h 1",
                     name, res_valid, job_ready, job_count, start_cnt - starts0, exp_jobs);
        end
    endtask

    task automatic test_single_job();
        run_job("single", 50, 32'h123, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_job("backpressure", 20, 32'hABCD, 10, 1'b1);
    endtask

    task automatic test_timeout();
        run_job("timeout", 0, 32'hDEAD, 2, 1'b0);
    endtask

    task automatic test_finish_last_cycle();
        run_job("last_cycle", 3 + TIMEOUT, 32'h7, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int  starts0;
        int  fin_at;
        int  n;
        bit  done;
        starts0 = start_cnt; fin_at = -1; n = 0; done = 1'b0;
        @(negedge clk);
        job_valid = 1'b1; res_ready = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (gen_start) begin
                fin_at       = k + 4 + n;
                gen_solution = 32'h100 + 32'(n);
                sb_q.push_back('{score: 32'h100 + 32'(n), timeout: 1'b0});
                n++;
            end
            gen_finish = (k == fin_at);
            if (job_count === exp_jobs + 16'd3) begin
                job_valid = 1'b0;
                done      = 1'b1;
            end
        end
        job_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL b2b_bound: got job_count=%h after 300 cycles, required %h", job_count, exp_jobs + 16'd3);
        end
        @(negedge clk);
        res_ready = 1'b0; gen_finish = 1'b0;
        exp_jobs  = exp_jobs + 16'd3;
        checks++;
        if (start_cnt - starts0 != 3 || busy !== 1'b0 || job_count !== exp_jobs) begin
            errors++;
            $display("FAIL b2b_count: got starts=%0d busy=%b jc=%h, required 3 0 %h",
                     start_cnt - starts0, busy, job_count, exp_jobs);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        job_valid = 1'b1;
        repeat (10) @(negedge clk);
        job_valid = 1'b0;
        reset     = 1'b0;
        #1;
        sb_q.delete();
        exp_jobs = '0;
        checks++;
        if (gen_reset !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || gen_start !== 1'b0 || job_count !== 16'h0) begin
            errors++;
            $display("FAIL midrun_reset: got rst=%b rv=%b busy=%b st=%b jc=%h, required 1 0 0 0 0",
                     gen_reset, res_valid, busy, gen_start, job_count);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (job_ready !== 1'b1 || gen_reset !== 1'b0) begin
            errors++;
            $display("FAIL midrun_release: got job_ready=%b gen_reset=%b, required 1 0", job_ready, gen_reset);
        end
        gen_finish = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0 || busy !== 1'b0 || gen_start !== 1'b0 || job_count !== 16'h0) begin
                errors++;
                $display("FAIL stray_finish%0d: got rv=%b busy=%b st=%b jc=%h, required 0 0 0 0",
                         k, res_valid, busy, gen_start, job_count);
            end
        end
        gen_finish = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_backpressure();
        test_timeout();
        test_finish_last_cycle();
        test_back_to_back();
        test_reset_mid_run();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending results, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alignment_controller.md
ALIGNMENT_CONTROLLER -- requirements
Module: alignment_controller

Interface
REQ-001 Parameter N, default 100, query-sequence length (rows) of the systolic generator.
REQ-002 Parameter M, default 200, number of processing-unit columns.
REQ-003 Parameter TIMEOUT, default N+M+16, maximum RUN cycles before abort.
REQ-004 Parameter CLR_CYCLES, default 2, cycles gen_reset is held before launch.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low controller reset.
REQ-007 job_valid  in  1  host requests an alignment run.
REQ-008 job_ready  out  1  controller can accept a job.
REQ-009 res_valid  out  1  result available.
REQ-010 res_ready  in  1  host consumes result.
REQ-011 res_score  out  32  captured alignment score.
REQ-012 res_timeout  out  1  run aborted by timeout.
REQ-013 gen_reset  out  1  active-high clear to generator.
REQ-014 gen_start  out  1  one-cycle start pulse to generator.
REQ-015 gen_finish  in  1  generator completion flag.
REQ-016 gen_solution  in  32  generator score.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 job_count  out  16  completed (acknowledged) jobs, wraps 0xFFFF->0.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, LAUNCH, RUN, HOLD.
REQ-020 IDLE: job_ready=1; job_valid&&job_ready -> CLEAR; otherwise stay.
REQ-021 CLEAR: gen_reset=1 for exactly CLR_CYCLES cycles (counter), then -> LAUNCH.
REQ-022 LAUNCH: gen_start=1 for exactly one cycle, cycle counter cleared, -> RUN.
REQ-023 RUN: counter increments each cycle; gen_finish=1 -> res_score<=gen_solution, res_timeout<=0, -> HOLD.
REQ-024 RUN: counter reaches TIMEOUT-1 with gen_finish=0 -> res_score<=0, res_timeout<=1, -> HOLD.
REQ-025 Finish and timeout in the same cycle: finish wins (score captured, res_timeout=0).
REQ-026 HOLD: res_valid=1, res_score/res_timeout stable; res_valid&&res_ready -> IDLE, job_count+1.
REQ-027 job_ready=0 outside IDLE; job_valid there SHALL be ignored, not queued.
REQ-028 gen_finish outside RUN SHALL be ignored.
REQ-029 Latency: job accepted edge t -> gen_reset cycles t+1..t+CLR_CYCLES, gen_start at t+CLR_CYCLES+1, res_valid cycle after finish sampled.
REQ-030 Counter width SHALL be $clog2(TIMEOUT+1); no overflow possible.
REQ-031 gen_reset, gen_start, res_valid, job_ready, busy SHALL be decoded from registered state (glitch-free).

Reset
REQ-032 reset low SHALL immediately force IDLE, counters 0, job_count 0, res_score 0, res_timeout 0, res_valid 0, gen_start 0.
REQ-033 gen_reset SHALL be 1 while reset is low, so the generator is cleared with the controller.
REQ-034 Reset mid-run SHALL abort without res_valid; first cycle after release job_ready=1.

Structure
REQ-035 Package alignment_pkg SHALL hold ctrl_state_t enum, SCORE_W=32, default N and M.
REQ-036 One sub-module alignment_timer (load, enable, expire) SHALL implement CLEAR and RUN counting; generator stays external.

Verification
REQ-037 Single job: job_valid at t0, model finish at t0+50 with 0x123 -> gen_reset t0+1..t0+2, gen_start t0+3, res_valid t0+51, score 0x123, timeout 0, job_count 1 after ack.
REQ-038 Backpressure: res_ready low 10 cycles, job_valid held -> res_valid/score stable, job_ready 0, no second gen_start.
REQ-039 Timeout: no finish -> res_valid after 316 RUN cycles, res_timeout 1, res_score 0.
REQ-040 Finish on last RUN cycle (316th) with 0x7 -> res_score 0x7, res_timeout 0.
REQ-041 Reset low during RUN, later stray gen_finish -> gen_reset 1 at once, no res_valid, job_count 0.
REQ-042 Back-to-back: job_valid and res_ready held high, 3 jobs -> exactly 3 gen_start pulses, job_count 3.
